symbol_sequencer: RTL

SYMBOL_SEQUENCER -- requirements
Module: symbol_sequencer

---
 rtl/seg_pkg.sv | 18 +
 rtl/rise_detect.sv | 25 ++
 rtl/symbol_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared display code constants, sequencer states and tick-width helper
package seg_pkg;

    localparam int CODE_W = 6;
    localparam logic [CODE_W-1:0] CODE_BLANK = 6'd63;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP,
        DONE
    } state_t;

    function automatic int tick_width(input int t, input int g);
        return $clog2((t > g ? t : g) + 1);
    endfunction

endpackage

// File: rtl/rise_detect.sv
// rise_detect: registered rising-edge detector, blind for the first cycle after reset
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic prev;
    logic armed;

    // remember last level; armed keeps a level already high at reset release from firing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            prev  <= d;
            armed <= 1'b1;
        end
    end

    assign pulse = d & ~prev & armed;

endmodule

// File: rtl/symbol_sequencer.sv
// symbol_sequencer: plays a stored message of display codes with per-symbol timing and gaps
module symbol_sequencer
    import seg_pkg::*;
#(
    parameter int TICKS_PER_SYM = 4,
    parameter int GAP_TICKS     = 1,
    parameter int DEPTH         = 16
) (
    input  logic              clk_2,
    input  logic              reset,
    input  logic              start,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [4:0]        msg_len,
    input  logic              wr_en,
    input  logic [3:0]        wr_addr,
    input  logic [CODE_W-1:0] wr_data,
    output logic [CODE_W-1:0] code,
    output logic              busy,
    output logic              done,
    output logic [3:0]        idx
);

    localparam int TW = tick_width(TICKS_PER_SYM, GAP_TICKS);

    logic [CODE_W-1:0] mem [DEPTH];
    state_t            state, state_n;
    logic [TW-1:0]     tick, tick_n;
    logic [3:0]        idx_n, idx_inc;
    logic [4:0]        len, len_n;
    logic [CODE_W-1:0] code_n, first_code;
    logic              start_p, wr_ok, accept, last;

    rise_detect u_rise (
        .clk   (clk_2),
        .rst   (reset),
        .d     (start),
        .pulse (start_p)
    );

    assign busy       = (state == SHOW) || (state == GAP);
    assign done       = (state == DONE);
    assign wr_ok      = wr_en && !busy;
    assign accept     = start_p && (state == IDLE) && (msg_len != 5'd0);
    assign last       = ({1'b0, idx} == len - 5'd1);
    assign idx_inc    = last ? 4'd0 : idx + 4'd1;
    assign first_code = (wr_ok && wr_addr == 4'd0) ? wr_data : mem[0];

    // message memory: blank on reset, writable only while not playing
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= CODE_BLANK;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // playback state register
    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            tick  <= '0;
            idx   <= 4'd0;
            len   <= 5'd0;
            code  <= CODE_BLANK;
        end else begin
            state <= state_n;
            tick  <= tick_n;
            idx   <= idx_n;
            len   <= len_n;
            code  <= code_n;
        end
    end

    // next state: pause freezes SHOW/GAP entirely, code is loaded on entry to each phase
    always_comb begin
        state_n = state;
        tick_n  = tick;
        idx_n   = idx;
        len_n   = len;
        code_n  = code;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = SHOW;
                    tick_n  = '0;
                    idx_n   = 4'd0;
                    len_n   = (msg_len > 5'(DEPTH)) ? 5'(DEPTH) : msg_len;
                    code_n  = first_code;
                end
            end
            SHOW: begin
                if (!pause) begin
                    if (tick == TW'(TICKS_PER_SYM - 1)) begin
                        tick_n = '0;
                        if (last && !loop_en) begin
                            state_n = DONE;
                            idx_n   = 4'd0;
                            code_n  = CODE_BLANK;
                        end else if (GAP_TICKS == 0) begin
                            idx_n  = idx_inc;
                            code_n = mem[idx_inc];
                        end else begin
                            state_n = GAP;
                            code_n  = CODE_BLANK;
                        end
                    end else begin
                        tick_n = tick + 1'b1;
                    end
                end
            end
            GAP: begin
                if (!pause) begin
                    if (tick == TW'(GAP_TICKS - 1)) begin
                        tick_n  = '0;
                        state_n = SHOW;
                        idx_n   = idx_inc;
                        code_n  = mem[idx_inc];
                    end else begin
                        tick_n = tick + 1'b1;
                    end
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

endmodule
